// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared opcodes, decode states and control decode for the decode stage
package pipeline_pkg;

    // Opcode groups, selected by opCode[4:3]
    localparam logic [1:0] GRP_MISC     = 2'b00;
    localparam logic [1:0] GRP_ALU      = 2'b01;
    localparam logic [1:0] GRP_STACK    = 2'b10;
    localparam logic [1:0] GRP_TWO_WORD = 2'b11;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_SETC = 5'b00001;
    localparam logic [4:0] OP_NOT  = 5'b00010;
    localparam logic [4:0] OP_INC  = 5'b00011;
    localparam logic [4:0] OP_OUT  = 5'b00100;
    localparam logic [4:0] OP_IN   = 5'b00101;
    localparam logic [4:0] OP_MOV  = 5'b01000;
    localparam logic [4:0] OP_ADD  = 5'b01001;
    localparam logic [4:0] OP_SUB  = 5'b01010;
    localparam logic [4:0] OP_AND  = 5'b01011;
    localparam logic [4:0] OP_OR   = 5'b01100;
    localparam logic [4:0] OP_SHL  = 5'b01101;
    localparam logic [4:0] OP_SHR  = 5'b01110;
    localparam logic [4:0] OP_PUSH = 5'b10000;
    localparam logic [4:0] OP_POP  = 5'b10001;
    localparam logic [4:0] OP_JZ   = 5'b10010;
    localparam logic [4:0] OP_JC   = 5'b10011;
    localparam logic [4:0] OP_JMP  = 5'b10100;
    localparam logic [4:0] OP_CALL = 5'b10101;
    localparam logic [4:0] OP_RET  = 5'b10110;
    localparam logic [4:0] OP_RTI  = 5'b10111;
    localparam logic [4:0] OP_IADD = 5'b11000;
    localparam logic [4:0] OP_LDM  = 5'b11001;
    localparam logic [4:0] OP_LDD  = 5'b11010;
    localparam logic [4:0] OP_STD  = 5'b11011;

    typedef enum logic {
        S_FIRST = 1'b0,
        S_IMM   = 1'b1
    } dec_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    // Reserved 11xxx codes still occupy two words so fetch stays aligned
    function automatic logic is_two_word(input logic [4:0] op);
        return op[4:3] == GRP_TWO_WORD;
    endfunction

    function automatic ctrl_t decode_ctrl(input logic [4:0] op);
        ctrl_t c;
        c.reg_write = (op[4:3] == GRP_ALU) ||
                      (op == OP_NOT)  || (op == OP_INC) || (op == OP_IN) ||
                      (op == OP_POP)  || (op == OP_IADD) ||
                      (op == OP_LDM)  || (op == OP_LDD);
        c.mem_read  = (op == OP_POP)  || (op == OP_LDD);
        c.mem_write = (op == OP_PUSH) || (op == OP_STD);
        return c;
    endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 2-read/1-write register file with write-first bypass
module register_file #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);

    localparam int DEPTH = 1 << REG_AW;

    logic [DATA_W-1:0] regs [DEPTH];

    // Single write port, whole array cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A same-cycle write is forwarded so decode never sees a stale value
    assign ra_data = (wr_en && (wr_addr == ra_addr)) ? wr_data : regs[ra_addr];
    assign rb_data = (wr_en && (wr_addr == rb_addr)) ? wr_data : regs[rb_addr];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - IF/ID consumer: one/two-word decode, register read, ID/EX buffer
module decode_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   nextInstructionAddress,
    input  logic [4:0]        opCode,
    input  logic [REG_AW-1:0] Rs,
    input  logic [REG_AW-1:0] Rd,
    input  logic [4:0]        SHMNT,
    input  logic [15:0]       Inst_as_Imm_value,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              LDM_signal,
    output logic              ex_valid,
    output logic [4:0]        ex_op,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rd,
    output logic [4:0]        ex_shmnt,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rd_data,
    output logic [15:0]       ex_imm,
    output logic [PC_W-1:0]   ex_pc,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write
);

    dec_state_t state_q, state_d;
    logic take_first, hold_first, take_imm, clear_valid;

    logic [DATA_W-1:0] rs_data, rd_data;

    // First word of a two-word instruction, parked until the immediate arrives
    logic [4:0]        h_op;
    logic [REG_AW-1:0] h_rs, h_rd;
    logic [4:0]        h_shmnt;
    logic [DATA_W-1:0] h_rs_data, h_rd_data;
    logic [PC_W-1:0]   h_pc;

    ctrl_t first_ctrl, held_ctrl;
    assign first_ctrl = decode_ctrl(opCode);
    assign held_ctrl  = decode_ctrl(h_op);

    register_file #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regs (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (wb_en),
        .wr_addr (wb_addr),
        .wr_data (wb_data),
        .ra_addr (Rs),
        .rb_addr (Rd),
        .ra_data (rs_data),
        .rb_data (rd_data)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath load strobes; flush outranks stall
    always_comb begin
        state_d     = state_q;
        take_first  = 1'b0;
        hold_first  = 1'b0;
        take_imm    = 1'b0;
        clear_valid = 1'b0;
        if (flush) begin
            state_d     = S_FIRST;
            clear_valid = 1'b1;
        end else if (!stall) begin
            case (state_q)
                S_FIRST: begin
                    if (is_two_word(opCode)) begin
                        hold_first  = 1'b1;
                        clear_valid = 1'b1;
                        state_d     = S_IMM;
                    end else begin
                        take_first = 1'b1;
                    end
                end
                S_IMM: begin
                    take_imm = 1'b1;
                    state_d  = S_FIRST;
                end
                default: state_d = S_FIRST;
            endcase
        end
    end

    // Fetch must treat the next word as raw data whenever we wait for it
    assign LDM_signal = (state_q == S_IMM);

    // Holding registers capture fields and reads of the first word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_op      <= '0;
            h_rs      <= '0;
            h_rd      <= '0;
            h_shmnt   <= '0;
            h_rs_data <= '0;
            h_rd_data <= '0;
            h_pc      <= '0;
        end else if (hold_first) begin
            h_op      <= opCode;
            h_rs      <= Rs;
            h_rd      <= Rd;
            h_shmnt   <= SHMNT;
            h_rs_data <= rs_data;
            h_rd_data <= rd_data;
            h_pc      <= nextInstructionAddress;
        end
    end

    // ID/EX buffer: loaded by a complete instruction, otherwise holds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_op        <= '0;
            ex_rs        <= '0;
            ex_rd        <= '0;
            ex_shmnt     <= '0;
            ex_rs_data   <= '0;
            ex_rd_data   <= '0;
            ex_imm       <= '0;
            ex_pc        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (clear_valid) begin
            ex_valid <= 1'b0;
        end else if (take_first) begin
            ex_valid     <= 1'b1;
            ex_op        <= opCode;
            ex_rs        <= Rs;
            ex_rd        <= Rd;
            ex_shmnt     <= SHMNT;
            ex_rs_data   <= rs_data;
            ex_rd_data   <= rd_data;
            ex_imm       <= '0;
            ex_pc        <= nextInstructionAddress;
            ex_reg_write <= first_ctrl.reg_write;
            ex_mem_read  <= first_ctrl.mem_read;
            ex_mem_write <= first_ctrl.mem_write;
        end else if (take_imm) begin
            ex_valid     <= 1'b1;
            ex_op        <= h_op;
            ex_rs        <= h_rs;
            ex_rd        <= h_rd;
            ex_shmnt     <= h_shmnt;
            ex_rs_data   <= h_rs_data;
            ex_rd_data   <= h_rd_data;
            ex_imm       <= Inst_as_Imm_value;
            ex_pc        <= h_pc;
            ex_reg_write <= held_ctrl.reg_write;
            ex_mem_read  <= held_ctrl.mem_read;
            ex_mem_write <= held_ctrl.mem_write;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] nextInstructionAddress;
    logic [4:0]  opCode;
    logic [2:0]  Rs, Rd;
    logic [4:0]  SHMNT;
    logic [15:0] Inst_as_Imm_value;
    logic        stall, flush, wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        LDM_signal, ex_valid;
    logic [4:0]  ex_op;
    logic [2:0]  ex_rs, ex_rd;
    logic [4:0]  ex_shmnt;
    logic [15:0] ex_rs_data, ex_rd_data, ex_imm;
    logic [31:0] ex_pc;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;

    int n_cmp = 0;
    int n_bad = 0;

    decode_stage dut (
        .clk                    (clk),
        .reset                  (reset),
        .nextInstructionAddress (nextInstructionAddress),
        .opCode                 (opCode),
        .Rs                     (Rs),
        .Rd                     (Rd),
        .SHMNT                  (SHMNT),
        .Inst_as_Imm_value      (Inst_as_Imm_value),
        .stall                  (stall),
        .flush                  (flush),
        .wb_en                  (wb_en),
        .wb_addr                (wb_addr),
        .wb_data                (wb_data),
        .LDM_signal             (LDM_signal),
        .ex_valid               (ex_valid),
        .ex_op                  (ex_op),
        .ex_rs                  (ex_rs),
        .ex_rd                  (ex_rd),
        .ex_shmnt               (ex_shmnt),
        .ex_rs_data             (ex_rs_data),
        .ex_rd_data             (ex_rd_data),
        .ex_imm                 (ex_imm),
        .ex_pc                  (ex_pc),
        .ex_reg_write           (ex_reg_write),
        .ex_mem_read            (ex_mem_read),
        .ex_mem_write           (ex_mem_write)
    );

    always #5 clk = ~clk;

    logic [100:0] act_vec;
    assign act_vec = {LDM_signal, ex_valid, ex_op, ex_rs, ex_rd, ex_shmnt, ex_rs_data,
                      ex_rd_data, ex_imm, ex_pc, ex_reg_write, ex_mem_read, ex_mem_write};

    // Reference model: architectural registers plus the expected ID/EX contents
    logic [15:0] m_regs [8];
    logic        m_wait_imm;
    logic [4:0]  p_op;
    logic [2:0]  p_rs, p_rd;
    logic [4:0]  p_sh;
    logic [15:0] p_rsd, p_rdd;
    logic [31:0] p_pc;
    logic        m_valid;
    logic [4:0]  m_op;
    logic [2:0]  m_rs, m_rd;
    logic [4:0]  m_sh;
    logic [15:0] m_rsd, m_rdd, m_imm;
    logic [31:0] m_pc;

    function automatic logic [2:0] ref_ctrl(input logic [4:0] op);
        logic rw, mr, mw;
        rw = (op inside {[5'd8:5'd15], 5'd2, 5'd3, 5'd5, 5'd17, 5'd24, 5'd25, 5'd26});
        mr = (op inside {5'd17, 5'd26});
        mw = (op inside {5'd16, 5'd27});
        return {rw, mr, mw};
    endfunction

    function automatic logic [15:0] ref_read(input logic [2:0] a);
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [100:0] ref_vec();
        return {m_wait_imm, m_valid, m_op, m_rs, m_rd, m_sh, m_rsd, m_rdd, m_imm, m_pc, ref_ctrl(m_op)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_wait_imm = 0; m_valid = 0; m_op = 0; m_rs = 0; m_rd = 0; m_sh = 0;
        m_rsd = 0; m_rdd = 0; m_imm = 0; m_pc = 0;
        p_op = 0; p_rs = 0; p_rd = 0; p_sh = 0; p_rsd = 0; p_rdd = 0; p_pc = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        if (flush) begin
            m_wait_imm = 0;
            m_valid    = 0;
        end else if (!stall) begin
            if (m_wait_imm) begin
                m_valid = 1; m_op = p_op; m_rs = p_rs; m_rd = p_rd; m_sh = p_sh;
                m_rsd = p_rsd; m_rdd = p_rdd; m_pc = p_pc; m_imm = Inst_as_Imm_value;
                m_wait_imm = 0;
            end else if (opCode >= 5'd24) begin
                p_op = opCode; p_rs = Rs; p_rd = Rd; p_sh = SHMNT;
                p_rsd = ref_read(Rs); p_rdd = ref_read(Rd); p_pc = nextInstructionAddress;
                m_valid = 0;
                m_wait_imm = 1;
            end else begin
                m_valid = 1; m_op = opCode; m_rs = Rs; m_rd = Rd; m_sh = SHMNT;
                m_rsd = ref_read(Rs); m_rdd = ref_read(Rd); m_pc = nextInstructionAddress;
                m_imm = 0;
            end
        end
        if (wb_en) m_regs[wb_addr] = wb_data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rd,
                           input logic [15:0] word, input logic [31:0] pc);
        opCode = op; Rs = rs; Rd = rd; SHMNT = word[4:0];
        Inst_as_Imm_value = word; nextInstructionAddress = pc;
    endtask

    task automatic test_reset();
        reset = 0; stall = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        present(5'd0, 3'd0, 3'd0, 16'h0, 32'h0);
        #3;
        n_cmp++;
        if (act_vec !== 101'd0) begin
            n_bad++; $display("FAIL reset_state: got %h want 0", act_vec);
        end
        @(negedge clk) reset = 1;
        #4;
        present(5'b01001, 3'd1, 3'd2, 16'h4A11, 32'h10);
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_add: got valid %b want 1", ex_valid);
        end
        present(5'b11001, 3'd0, 3'd1, 16'hC801, 32'h11);
        tick();
        n_cmp++;
        if (LDM_signal !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_ldm: got LDM_signal %b want 1", LDM_signal);
        end
        #2 reset = 0;
        #1;
        n_cmp++;
        if (act_vec !== 101'd0) begin
            n_bad++; $display("FAIL async_reset_mid_imm: got %h want 0", act_vec);
        end
        #2 reset = 1;
        present(5'b01001, 3'd4, 3'd5, 16'h4C05, 32'h20);
        tick();
        n_cmp++;
        if ({ex_valid, ex_op, LDM_signal, ex_pc} !== {1'b1, 5'b01001, 1'b0, 32'h20}) begin
            n_bad++;
            $display("FAIL add_after_reset: got v=%b op=%b ldm=%b pc=%h want 1 01001 0 20",
                     ex_valid, ex_op, LDM_signal, ex_pc);
        end
    endtask

    task automatic test_one_word();
        wb_en = 1; wb_addr = 3'd3; wb_data = 16'h00A5;
        present(5'b00000, 3'd0, 3'd0, 16'h0, 32'h30);
        tick();
        wb_en = 0;
        present(5'b01001, 3'd3, 3'd2, 16'h4B02, 32'h31);
        tick();
        n_cmp++;
        if ({ex_valid, ex_op, ex_rs_data, ex_reg_write, ex_imm} !== {1'b1, 5'b01001, 16'h00A5, 1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL add_one_word: got v=%b op=%b rs_data=%h rw=%b imm=%h want 1 01001 00a5 1 0000",
                     ex_valid, ex_op, ex_rs_data, ex_reg_write, ex_imm);
        end
    endtask

    task automatic test_ldm();
        present(5'b11001, 3'd0, 3'd1, 16'hC801, 32'h40);
        tick();
        n_cmp++;
        if ({LDM_signal, ex_valid} !== 2'b10) begin
            n_bad++; $display("FAIL ldm_first_word: got ldm=%b v=%b want 1 0", LDM_signal, ex_valid);
        end
        present(5'b01010, 3'd6, 3'd7, 16'h1234, 32'h41);
        tick();
        n_cmp++;
        if ({ex_valid, ex_op, ex_rd, ex_imm, LDM_signal, ex_pc} !== {1'b1, 5'b11001, 3'd1, 16'h1234, 1'b0, 32'h40}) begin
            n_bad++;
            $display("FAIL ldm_imm_word: got v=%b op=%b rd=%0d imm=%h ldm=%b pc=%h want 1 11001 1 1234 0 40",
                     ex_valid, ex_op, ex_rd, ex_imm, LDM_signal, ex_pc);
        end
    endtask

    task automatic test_stall();
        present(5'b11011, 3'd4, 3'd5, 16'hDC05, 32'h50);
        tick();
        stall = 1;
        present(5'b00000, 3'd0, 3'd0, 16'h00FF, 32'h51);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({LDM_signal, ex_valid, ex_op, ex_imm} !== {1'b1, 1'b0, 5'b11001, 16'h1234}) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: got ldm=%b v=%b op=%b imm=%h want 1 0 11001 1234",
                         i, LDM_signal, ex_valid, ex_op, ex_imm);
            end
        end
        stall = 0;
        tick();
        n_cmp++;
        if ({ex_valid, ex_op, ex_rs, ex_rd, ex_imm, ex_mem_write, ex_reg_write, ex_pc, LDM_signal}
            !== {1'b1, 5'b11011, 3'd4, 3'd5, 16'h00FF, 1'b1, 1'b0, 32'h50, 1'b0}) begin
            n_bad++;
            $display("FAIL std_after_stall: got v=%b op=%b rs=%0d rd=%0d imm=%h mw=%b rw=%b pc=%h ldm=%b",
                     ex_valid, ex_op, ex_rs, ex_rd, ex_imm, ex_mem_write, ex_reg_write, ex_pc, LDM_signal);
        end
    endtask

    task automatic test_flush();
        present(5'b11000, 3'd1, 3'd2, 16'hC102, 32'h60);
        tick();
        flush = 1;
        present(5'b10000, 3'd6, 3'd0, 16'h8600, 32'h61);
        tick();
        n_cmp++;
        if ({LDM_signal, ex_valid, ex_op} !== {1'b0, 1'b0, 5'b11011}) begin
            n_bad++;
            $display("FAIL flush_in_imm: got ldm=%b v=%b op=%b want 0 0 11011", LDM_signal, ex_valid, ex_op);
        end
        flush = 0;
        tick();
        n_cmp++;
        if ({ex_op, ex_mem_write, ex_valid, ex_imm} !== {5'b10000, 1'b1, 1'b1, 16'h0}) begin
            n_bad++;
            $display("FAIL push_after_flush: got op=%b mw=%b v=%b imm=%h want 10000 1 1 0000",
                     ex_op, ex_mem_write, ex_valid, ex_imm);
        end
    endtask

    task automatic test_bypass();
        wb_en = 1; wb_addr = 3'd2; wb_data = 16'hBEEF;
        present(5'b01000, 3'd2, 3'd3, 16'h4203, 32'h70);
        tick();
        wb_en = 0;
        n_cmp++;
        if ({ex_valid, ex_op, ex_rs_data, ex_rd_data} !== {1'b1, 5'b01000, 16'hBEEF, 16'h00A5}) begin
            n_bad++;
            $display("FAIL mov_bypass: got v=%b op=%b rs_data=%h rd_data=%h want 1 01000 beef 00a5",
                     ex_valid, ex_op, ex_rs_data, ex_rd_data);
        end
        present(5'b11010, 3'd2, 3'd4, 16'hD204, 32'h71);
        tick();
        stall = 1; flush = 1;
        present(5'b00000, 3'd0, 3'd0, 16'h5555, 32'h72);
        tick();
        n_cmp++;
        if ({LDM_signal, ex_valid, ex_op} !== {1'b0, 1'b0, 5'b01000}) begin
            n_bad++;
            $display("FAIL flush_beats_stall: got ldm=%b v=%b op=%b want 0 0 01000", LDM_signal, ex_valid, ex_op);
        end
        stall = 0; flush = 0;
    endtask

    task automatic test_random();
        reset = 0; stall = 0; flush = 0; wb_en = 0;
        #2 reset = 1;
        model_reset();
        for (int i = 0; i < 500; i++) begin
            present(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    16'($urandom), $urandom);
            SHMNT   = 5'($urandom);
            stall   = ($urandom_range(0, 7) == 0);
            flush   = ($urandom_range(0, 15) == 0);
            wb_en   = ($urandom_range(0, 1) == 0);
            wb_addr = 3'($urandom_range(0, 7));
            wb_data = 16'($urandom);
            model_step();
            tick();
            n_cmp++;
            if (act_vec !== ref_vec()) begin
                n_bad++;
                $display("FAIL random_cycle_%0d: got %h want %h", i, act_vec, ref_vec());
            end
        end
        stall = 0; flush = 0; wb_en = 0;
    endtask

    initial begin
        test_reset();
        test_one_word();
        test_ldm();
        test_stall();
        test_flush();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
